ppu_sprite_eval_fsm: RTL

Parametrised per-scanline sprite evaluator for the PPU. On `start` it scans primary OAM from `cpu_sprite_addr`, copies up to `NUM_SLOTS` sprites covering `curr_row` into a double-buffered secondary store, and raises the sprite-overflow flag. It supports 8x8 and 8x16 sprite heights. It sits between sprite RAM and the pixel pipeline. The renderer reads the previous line's slots through an indexed port while the next line is evaluated.

---
 rtl/ppu_sprite_pkg.sv | 38 +++
 rtl/ppu_sprite_slot_bank.sv | 79 +++++++
 rtl/ppu_sprite_eval_fsm.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppu_sprite_pkg
// Description : Shared types and constants for the per-scanline sprite
//               evaluator: sprite record, FSM state encoding, OAM geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package ppu_sprite_pkg;

    localparam int SPRITE_BYTES = 4;
    localparam int ROWS_8       = 8;
    localparam int ROWS_16      = 16;

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] tile;
        logic [7:0] attr;
        logic [7:0] x;
        logic       valid;
        logic       is_0;
    } sprite_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_CHECK     = 3'd2,
        S_COPY      = 3'd3,
        S_OVF_ISSUE = 3'd4,
        S_OVF_CHECK = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    // Contents of an empty slot: Y parked off-screen, nothing valid.
    localparam sprite_t SPRITE_CLEAR = '{y: 8'hFF, tile: 8'h00, attr: 8'h00,
                                         x: 8'h00, valid: 1'b0, is_0: 1'b0};

endpackage
`default_nettype wire

// File: rtl/ppu_sprite_slot_bank.sv
`default_nettype none
// ============================================================================
// Module      : ppu_sprite_slot_bank
// Description : Double-buffered secondary sprite store. The evaluator writes
//               the back bank byte by byte; the renderer reads the front bank
//               through a registered indexed port. swap exchanges the banks.
// Revision    : 1.0 - initial release
// ============================================================================
module ppu_sprite_slot_bank
    import ppu_sprite_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_idx,
    input  logic [1:0]        wr_byte,
    input  logic [7:0]        wr_data,
    input  logic              wr_is_0,
    input  logic              swap,
    input  logic [SLOT_W-1:0] rd_sel,
    output sprite_t           rd_data
);

    sprite_t r_bank [2][NUM_SLOTS];
    sprite_t r_rd;
    logic    r_front;
    logic    w_back;

    assign w_back  = ~r_front;
    assign rd_data = r_rd;

    // Bank storage: clear/write target the back bank, swap flips ownership.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_front <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    r_bank[b][i] <= SPRITE_CLEAR;
                end
            end
        end else begin
            if (swap) begin
                r_front <= ~r_front;
            end
            if (clr) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    r_bank[w_back][i] <= SPRITE_CLEAR;
                end
            end
            if (wr_en) begin
                case (wr_byte)
                    2'd0: begin
                        r_bank[w_back][wr_idx].y     <= wr_data;
                        r_bank[w_back][wr_idx].valid <= 1'b1;
                        r_bank[w_back][wr_idx].is_0  <= wr_is_0;
                    end
                    2'd1:    r_bank[w_back][wr_idx].tile <= wr_data;
                    2'd2:    r_bank[w_back][wr_idx].attr <= wr_data;
                    default: r_bank[w_back][wr_idx].x    <= wr_data;
                endcase
            end
        end
    end

    // Registered renderer read port on the front bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd <= SPRITE_CLEAR;
        end else begin
            r_rd <= r_bank[r_front][rd_sel];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ppu_sprite_eval_fsm.sv
`default_nettype none
// ============================================================================
// Module      : ppu_sprite_eval_fsm
// Description : Per-scanline sprite evaluator. Scans primary OAM, copies up to
//               NUM_SLOTS sprites covering the latched row into the back bank
//               of a double-buffered store and reports sprite overflow.
//               Optional macro PPU_SPRITE_OVF_BUG_EN reproduces the 2C02
//               diagonal overflow scan (byte offset m advancing on misses).
// Revision    : 1.0 - initial release
// ============================================================================
module ppu_sprite_eval_fsm
    import ppu_sprite_pkg::*;
#(
    parameter int NUM_SLOTS = 8,
    parameter int NUM_OAM   = 64,
    parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [7:0]        spram_addr,
    input  logic [7:0]        spram_data_in,
    input  logic [7:0]        cpu_sprite_addr,
    input  logic [8:0]        curr_row,
    input  logic              sprite_size,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [SLOT_W-1:0] slot_sel,
    output logic              slot_valid,
    output logic [7:0]        slot_y,
    output logic [7:0]        slot_tile,
    output logic [7:0]        slot_attr,
    output logic [7:0]        slot_x,
    output logic              slot_is_0,
    output logic [SLOT_W:0]   sprite_count,
    output logic              sprite_overflow,
    output logic              sprite0_on_line
);

    localparam int c_n_w = $clog2(NUM_OAM + 1);

    state_t            r_state, w_next;
    logic [c_n_w-1:0]  r_n;
    logic [SLOT_W:0]   r_hits;
    logic [1:0]        r_copy;
    logic [8:0]        r_row;
    logic              r_size;
    logic [7:0]        r_base;
    logic              r_ovf;
    logic              r_s0;
`ifdef PPU_SPRITE_OVF_BUG_EN
    logic [1:0]        r_m;
`endif

    logic [1:0] w_off;
    logic [7:0] w_addr;
    logic [8:0] w_diff;
    logic       w_hit, w_full, w_last;
    logic       w_clr, w_wr_en, w_swap;
    logic [1:0] w_wr_byte;
    sprite_t    w_rd;

    // Row coverage test in 9-bit unsigned arithmetic.
    assign w_diff = r_row - {1'b0, spram_data_in};
    assign w_hit  = (r_row >= {1'b0, spram_data_in}) &&
                    (w_diff < (r_size ? 9'(ROWS_16) : 9'(ROWS_8)));
    assign w_full = (r_hits == (SLOT_W+1)'(NUM_SLOTS));
    assign w_last = (r_n == c_n_w'(NUM_OAM - 1));

    // OAM address wraps modulo 256 from any (possibly misaligned) base.
    assign w_addr     = r_base + 8'(r_n * SPRITE_BYTES) + {6'd0, w_off};
    assign spram_addr = (r_state == S_IDLE) ? 8'h00 : w_addr;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);

    assign slot_valid = w_rd.valid;
    assign slot_y     = w_rd.y;
    assign slot_tile  = w_rd.tile;
    assign slot_attr  = w_rd.attr;
    assign slot_x     = w_rd.x;
    assign slot_is_0  = w_rd.is_0;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, address offset and slot-bank control strobes.
    always_comb begin
        w_next    = r_state;
        w_off     = 2'd0;
        w_clr     = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_byte = 2'd0;
        w_swap    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clr  = 1'b1;
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next = S_CHECK;
            end
            S_CHECK: begin
                w_off = 2'd1;
                if (w_hit && w_full) begin
                    w_next = S_OVF_ISSUE;
                end else if (w_hit) begin
                    w_wr_en = 1'b1;
                    w_next  = S_COPY;
                end else begin
                    w_next = w_last ? S_DONE : S_ISSUE;
                end
            end
            S_COPY: begin
                // Byte k+1 arrives while byte k+2 is being addressed.
                w_off     = r_copy + 2'd2;
                w_wr_en   = 1'b1;
                w_wr_byte = r_copy + 2'd1;
                if (r_copy == 2'd2) begin
                    if (w_last) begin
                        w_next = S_DONE;
                    end else if (r_hits == (SLOT_W+1)'(NUM_SLOTS - 1)) begin
                        w_next = S_OVF_ISSUE;
                    end else begin
                        w_next = S_ISSUE;
                    end
                end
            end
            S_OVF_ISSUE: begin
`ifdef PPU_SPRITE_OVF_BUG_EN
                w_off = r_m;
`else
                w_off = 2'd0;
`endif
                w_next = S_OVF_CHECK;
            end
            S_OVF_CHECK: begin
                if (w_hit || w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_OVF_ISSUE;
                end
            end
            S_DONE: begin
                w_swap = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Scan counters, latched evaluation context and published line results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n             <= '0;
            r_hits          <= '0;
            r_copy          <= 2'd0;
            r_row           <= 9'd0;
            r_size          <= 1'b0;
            r_base          <= 8'h00;
            r_ovf           <= 1'b0;
            r_s0            <= 1'b0;
            sprite_count    <= '0;
            sprite_overflow <= 1'b0;
            sprite0_on_line <= 1'b0;
`ifdef PPU_SPRITE_OVF_BUG_EN
            r_m             <= 2'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row  <= curr_row;
                        r_size <= sprite_size;
                        r_base <= cpu_sprite_addr;
                        r_n    <= '0;
                        r_hits <= '0;
                        r_copy <= 2'd0;
                        r_ovf  <= 1'b0;
                        r_s0   <= 1'b0;
`ifdef PPU_SPRITE_OVF_BUG_EN
                        r_m    <= 2'd0;
`endif
                    end
                end
                S_CHECK: begin
                    if (w_hit && !w_full) begin
                        r_copy <= 2'd0;
                        if (r_n == '0) begin
                            r_s0 <= 1'b1;
                        end
                    end else if (!w_hit) begin
                        r_n <= r_n + 1'b1;
                    end
                end
                S_COPY: begin
                    if (r_copy == 2'd2) begin
                        r_copy <= 2'd0;
                        r_hits <= r_hits + 1'b1;
                        r_n    <= r_n + 1'b1;
                    end else begin
                        r_copy <= r_copy + 2'd1;
                    end
                end
                S_OVF_CHECK: begin
                    if (w_hit) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_n <= r_n + 1'b1;
`ifdef PPU_SPRITE_OVF_BUG_EN
                        r_m <= r_m + 2'd1;
`endif
                    end
                end
                S_DONE: begin
                    sprite_count    <= r_hits;
                    sprite_overflow <= r_ovf;
                    sprite0_on_line <= r_s0;
                end
                default: ;
            endcase
        end
    end

    ppu_sprite_slot_bank #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_W    (SLOT_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .wr_en   (w_wr_en),
        .wr_idx  (r_hits[SLOT_W-1:0]),
        .wr_byte (w_wr_byte),
        .wr_data (spram_data_in),
        .wr_is_0 (r_n == '0),
        .swap    (w_swap),
        .rd_sel  (slot_sel),
        .rd_data (w_rd)
    );

endmodule
`default_nettype wire
